// File: rtl/usb_tx_ctrl.sv
// USB transmit packet sequencer.
// Walks a packet through SYNC, PID, payload, CRC16 and EOP, handing one byte
// at a time to the bit timer's shift register. The data CRC is accumulated
// as payload bytes are popped from the TX FIFO.
module usb_tx_ctrl #(
    parameter int MAX_LEN = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [3:0] tx_pid,
    input  logic [6:0] tx_len,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rdata,
    output logic       fifo_rd,
    input  logic       byte_sent,
    input  logic       data_sent,
    output logic       transmitting,
    output logic       transmit_empty,
    output logic [7:0] tx_byte,
    output logic       load_byte,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        PID,
        DATA,
        CRC_LO,
        CRC_HI,
        EOP
    } state_t;

    state_t      state_q;
    logic [3:0]  pid_q;
    logic [6:0]  len_q;
    logic [6:0]  byteCnt_q;
    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic [7:0]  txByte_q;
    logic        active_q;
    logic        loadByte_q;
    logic        fifoRd_q;
    logic        txEmpty_q;
    logic        txDone_q;
    logic        txError_q;

    // DATA0 and DATA1 carry a payload and CRC; every other PID is a handshake.
    function automatic logic isDataPid(input logic [3:0] p);
        return (p == 4'b0011) || (p == 4'b1011);
    endfunction

    // CRC-16/USB step over one byte, LSB first, reflected polynomial 0xA001.
    function automatic logic [15:0] crcUpdate(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ 16'hA001;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // CRC value the register takes if the current FIFO head is popped this cycle.
    always_comb begin
        crc_d = crcUpdate(crc_q, fifo_rdata);
    end

    // Packet sequencer; all outputs are registered and pulses self-clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            pid_q      <= 4'h0;
            len_q      <= 7'd0;
            byteCnt_q  <= 7'd0;
            crc_q      <= 16'hFFFF;
            txByte_q   <= 8'h00;
            active_q   <= 1'b0;
            loadByte_q <= 1'b0;
            fifoRd_q   <= 1'b0;
            txEmpty_q  <= 1'b0;
            txDone_q   <= 1'b0;
            txError_q  <= 1'b0;
        end else begin
            loadByte_q <= 1'b0;
            fifoRd_q   <= 1'b0;
            txEmpty_q  <= 1'b0;
            txDone_q   <= 1'b0;
            txError_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (tx_start) begin
                        if (isDataPid(tx_pid) && (32'(tx_len) > MAX_LEN)) begin
                            txError_q <= 1'b1;
                        end else begin
                            pid_q      <= tx_pid;
                            len_q      <= tx_len;
                            byteCnt_q  <= 7'd0;
                            crc_q      <= 16'hFFFF;
                            active_q   <= 1'b1;
                            txByte_q   <= 8'h80;
                            loadByte_q <= 1'b1;
                            state_q    <= SYNC;
                        end
                    end
                end
                SYNC: begin
                    if (byte_sent) begin
                        txByte_q   <= {~pid_q, pid_q};
                        loadByte_q <= 1'b1;
                        state_q    <= PID;
                    end
                end
                PID: begin
                    if (byte_sent) begin
                        if (!isDataPid(pid_q)) begin
                            txEmpty_q <= 1'b1;
                            state_q   <= EOP;
                        end else if (len_q == 7'd0) begin
                            txByte_q   <= ~crc_q[7:0];
                            loadByte_q <= 1'b1;
                            state_q    <= CRC_LO;
                        end else if (fifo_empty) begin
                            active_q  <= 1'b0;
                            txError_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            txByte_q   <= fifo_rdata;
                            loadByte_q <= 1'b1;
                            fifoRd_q   <= 1'b1;
                            crc_q      <= crc_d;
                            byteCnt_q  <= 7'd1;
                            state_q    <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (byte_sent) begin
                        if (byteCnt_q == len_q) begin
                            txByte_q   <= ~crc_q[7:0];
                            loadByte_q <= 1'b1;
                            state_q    <= CRC_LO;
                        end else if (fifo_empty) begin
                            active_q  <= 1'b0;
                            txError_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            txByte_q   <= fifo_rdata;
                            loadByte_q <= 1'b1;
                            fifoRd_q   <= 1'b1;
                            crc_q      <= crc_d;
                            byteCnt_q  <= byteCnt_q + 7'd1;
                        end
                    end
                end
                CRC_LO: begin
                    if (byte_sent) begin
                        txByte_q   <= ~crc_q[15:8];
                        loadByte_q <= 1'b1;
                        state_q    <= CRC_HI;
                    end
                end
                CRC_HI: begin
                    if (byte_sent) begin
                        txEmpty_q <= 1'b1;
                        state_q   <= EOP;
                    end
                end
                EOP: begin
                    if (data_sent) begin
                        active_q <= 1'b0;
                        txDone_q <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    active_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign fifo_rd        = fifoRd_q;
    assign transmitting   = active_q;
    assign busy           = active_q;
    assign transmit_empty = txEmpty_q;
    assign tx_byte        = txByte_q;
    assign load_byte      = loadByte_q;
    assign tx_done        = txDone_q;
    assign tx_error       = txError_q;

endmodule

// File: tb/tb_usb_tx_ctrl.sv
// Scoreboard testbench for usb_tx_ctrl: a reference model predicts the event
// stream of each packet, a bit-timer model answers the DUT, and a monitor
// checks every DUT event against the predicted stream.
module tb_usb_tx_ctrl;

    localparam logic [1:0] EV_LOAD  = 2'd0;
    localparam logic [1:0] EV_EMPTY = 2'd1;
    localparam logic [1:0] EV_DONE  = 2'd2;
    localparam logic [1:0] EV_ERROR = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] value;
    } exp_t;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       tx_start;
    logic [3:0] tx_pid;
    logic [6:0] tx_len;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       fifo_rd;
    logic       byte_sent;
    logic       data_sent;
    logic       transmitting;
    logic       transmit_empty;
    logic [7:0] tx_byte;
    logic       load_byte;
    logic       busy;
    logic       tx_done;
    logic       tx_error;

    exp_t       expQ[$];
    logic [7:0] fifoQ[$];
    logic [7:0] pktData[$];
    int         errors = 0;
    int         checks = 0;
    int         popCount = 0;

    usb_tx_ctrl #(.MAX_LEN(64)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .tx_start(tx_start),
        .tx_pid(tx_pid),
        .tx_len(tx_len),
        .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata),
        .fifo_rd(fifo_rd),
        .byte_sent(byte_sent),
        .data_sent(data_sent),
        .transmitting(transmitting),
        .transmit_empty(transmit_empty),
        .tx_byte(tx_byte),
        .load_byte(load_byte),
        .busy(busy),
        .tx_done(tx_done),
        .tx_error(tx_error)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    task automatic pushExp(input logic [1:0] kind, input logic [7:0] value);
        exp_t e;
        e.kind  = kind;
        e.value = value;
        expQ.push_back(e);
    endtask

    // Pops the next predicted event and compares it against what the DUT showed.
    task automatic popExpect(input string name, input logic [1:0] kind, input logic [7:0] value);
        exp_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: unexpected event, value 0x%0h, none expected", name, value);
        end else begin
            e = expQ.pop_front();
            checkOutput({name, "_kind"}, int'(kind), int'(e.kind));
            if (kind == EV_LOAD && e.kind == EV_LOAD) begin
                checkOutput({name, "_byte"}, int'(value), int'(e.value));
            end
        end
    endtask

    // CRC-16/USB of the first len bytes of pktData, already inverted for the wire.
    function automatic logic [15:0] refCrc(input int len);
        logic [15:0] crc;
        crc = 16'hFFFF;
        for (int i = 0; i < len; i++) begin
            crc = crc ^ {8'h00, pktData[i]};
            for (int b = 0; b < 8; b++) begin
                crc = crc[0] ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
            end
        end
        return ~crc;
    endfunction

    // Monitor: every DUT event on the falling edge is matched to the scoreboard.
    always @(negedge clk) begin
        if (n_rst) begin
            if (load_byte) begin
                checkOutput("transmitting_at_load", int'(transmitting), 1);
                popExpect("load_byte", EV_LOAD, tx_byte);
            end
            if (transmit_empty) popExpect("transmit_empty", EV_EMPTY, 8'h00);
            if (tx_done) popExpect("tx_done", EV_DONE, 8'h00);
            if (tx_error) popExpect("tx_error", EV_ERROR, 8'h00);
        end
    end

    // Show-ahead FIFO model: pops on fifo_rd and refreshes the head.
    always @(negedge clk) begin
        if (fifo_rd) begin
            popCount++;
            if (fifoQ.size() > 0) void'(fifoQ.pop_front());
        end
        fifo_empty = (fifoQ.size() == 0);
        fifo_rdata = (fifoQ.size() > 0) ? fifoQ[0] : 8'h00;
    end

    // Bit-timer model: answers each loaded byte and each end-of-packet request
    // after a random shifting delay.
    initial begin
        int bsCnt;
        int dsCnt;
        bsCnt = 0;
        dsCnt = 0;
        byte_sent = 1'b0;
        data_sent = 1'b0;
        forever begin
            @(negedge clk);
            byte_sent = 1'b0;
            data_sent = 1'b0;
            if (!n_rst) begin
                bsCnt = 0;
                dsCnt = 0;
            end else begin
                if (load_byte) begin
                    bsCnt = $urandom_range(2, 5);
                end else if (bsCnt > 0) begin
                    bsCnt--;
                    if (bsCnt == 0) byte_sent = 1'b1;
                end
                if (transmit_empty) begin
                    dsCnt = $urandom_range(2, 5);
                end else if (dsCnt > 0) begin
                    dsCnt--;
                    if (dsCnt == 0) data_sent = 1'b1;
                end
            end
        end
    end

    // Predicts the packet from the protocol rules, fills the FIFO, issues tx_start.
    task automatic startPacket(input logic [3:0] pid, input int len, input int avail,
                               output int expPops);
        logic        isData;
        logic        underrun;
        logic [15:0] crc;
        isData   = (pid == 4'b0011) || (pid == 4'b1011);
        underrun = 1'b0;
        expPops  = 0;
        if (isData && len > 64) begin
            pushExp(EV_ERROR, 8'h00);
        end else begin
            pushExp(EV_LOAD, 8'h80);
            pushExp(EV_LOAD, {~pid, pid});
            if (isData) begin
                for (int i = 0; i < len; i++) begin
                    if (i >= avail) begin
                        pushExp(EV_ERROR, 8'h00);
                        underrun = 1'b1;
                        break;
                    end
                    pushExp(EV_LOAD, pktData[i]);
                    expPops++;
                end
                if (!underrun) begin
                    crc = refCrc(len);
                    pushExp(EV_LOAD, crc[7:0]);
                    pushExp(EV_LOAD, crc[15:8]);
                end
            end
            if (!underrun) begin
                pushExp(EV_EMPTY, 8'h00);
                pushExp(EV_DONE, 8'h00);
            end
        end
        for (int i = 0; i < avail; i++) fifoQ.push_back(pktData[i]);
        popCount = 0;
        repeat (2) @(negedge clk);
        tx_pid   = pid;
        tx_len   = len[6:0];
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Runs one packet to completion and checks the end-of-packet state.
    task automatic applyStimulus(input logic [3:0] pid, input int len, input int avail);
        int   expPops;
        logic finished;
        logic sawBusy;
        logic badLen;
        badLen = ((pid == 4'b0011) || (pid == 4'b1011)) && (len > 64);
        startPacket(pid, len, avail, expPops);
        finished = 1'b0;
        sawBusy  = busy;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (busy) sawBusy = 1'b1;
            if (expQ.size() == 0 && !busy) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("[TB] FAIL packet_timeout: pid 0x%0h len %0d, %0d events still pending, required 0",
                     pid, len, expQ.size());
            expQ.delete();
        end
        repeat (3) @(negedge clk);
        checkOutput("fifo_pops", popCount, expPops);
        checkOutput("transmitting_after", int'(transmitting), 0);
        checkOutput("busy_after", int'(busy), 0);
        checkOutput("stray_events", expQ.size(), 0);
        if (badLen) checkOutput("busy_on_bad_len", int'(sawBusy), 0);
        fifoQ.delete();
        expQ.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_fifo_rd"}, int'(fifo_rd), 0);
        checkOutput({tag, "_transmitting"}, int'(transmitting), 0);
        checkOutput({tag, "_transmit_empty"}, int'(transmit_empty), 0);
        checkOutput({tag, "_tx_byte"}, int'(tx_byte), 0);
        checkOutput({tag, "_load_byte"}, int'(load_byte), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_tx_done"}, int'(tx_done), 0);
        checkOutput({tag, "_tx_error"}, int'(tx_error), 0);
    endtask

    task automatic loadAscii9();
        pktData.delete();
        for (int i = 0; i < 9; i++) pktData.push_back(8'h31 + 8'(i));
    endtask

    // Main sequence: directed scenarios, a mid-packet reset, then random packets.
    initial begin
        int         dummyPops;
        logic       hit;
        logic [3:0] pid;
        int         len;
        int         avail;
        int         sel;
        n_rst    = 1'b0;
        tx_start = 1'b0;
        tx_pid   = 4'h0;
        tx_len   = 7'd0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        pktData.delete();
        applyStimulus(4'b0010, 0, 0);
        applyStimulus(4'b0011, 0, 0);
        loadAscii9();
        applyStimulus(4'b1011, 9, 9);
        pktData.delete();
        for (int i = 0; i < 4; i++) pktData.push_back(8'($urandom));
        applyStimulus(4'b0011, 4, 2);
        applyStimulus(4'b0011, 65, 0);

        loadAscii9();
        startPacket(4'b1011, 9, 9, dummyPops);
        hit = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge clk);
            if (popCount >= 3) begin
                hit = 1'b1;
                break;
            end
        end
        checkOutput("reached_mid_data", int'(hit), 1);
        n_rst = 1'b0;
        #1;
        checkAllZero("midreset");
        expQ.delete();
        fifoQ.delete();
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (10) @(negedge clk);
        applyStimulus(4'b1011, 9, 9);

        for (int p = 0; p < 10; p++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0:       pid = 4'b0010;
                1:       pid = 4'b1010;
                2:       pid = 4'b1110;
                5:       pid = 4'b1011;
                default: pid = 4'b0011;
            endcase
            len = $urandom_range(0, 70);
            pktData.delete();
            for (int i = 0; i < len; i++) pktData.push_back(8'($urandom));
            if (!(pid == 4'b0011 || pid == 4'b1011) || len > 64) begin
                avail = 0;
            end else if ($urandom_range(0, 3) == 0) begin
                avail = $urandom_range(0, len);
            end else begin
                avail = len;
            end
            applyStimulus(pid, len, avail);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
